// File: rtl/retire_monitor.sv
// retire_monitor: counts core retires/cycles, captures last store, pages HEX displays via debounced key
// Define RETIRE_MON_BLANK_EN to blank leading zero digits on the counter pages.
module retire_monitor #(
  parameter int aW   = 6,
  parameter int Wwid = 6,
  parameter int CW   = 24,
  parameter int DBW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            retire,
  input  logic            halt,
  input  logic            writeEn,
  input  logic [aW-1:0]   memAddr,
  input  logic [Wwid-1:0] writeData,
  input  logic            key_n,
  output logic [1:0]      page,
  output logic            halted,
  output logic [6:0]      HEX0,
  output logic [6:0]      HEX1,
  output logic [6:0]      HEX2,
  output logic [6:0]      HEX3,
  output logic [6:0]      HEX4,
  output logic [6:0]      HEX5
);
  typedef enum logic [1:0] {P0 = 2'd0, P1 = 2'd1, P2 = 2'd2} page_t;
  page_t state, state_nx;
  logic retire_q, halt_q, we_q;
  logic [aW-1:0] addr_q, last_addr;
  logic [Wwid-1:0] data_q, last_data;
  logic [CW-1:0] retire_cnt, cycle_cnt;
  logic [7:0] st_cnt;
  logic [1:0] ks_sync;
  logic ks, stable, press;
  logic [DBW-1:0] dbc;
  logic [23:0] disp;
  logic [6:0] seg_nx [6];
  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  endfunction
  assign ks = ks_sync[1];
  // event fires on the clock the debouncer accepts a 1->0 transition
  assign press = stable && !ks && (&dbc);
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_q   <= 1'b0;
      halt_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      retire_cnt <= '0;
      cycle_cnt  <= '0;
      halted     <= 1'b0;
      last_addr  <= '0;
      last_data  <= '0;
      st_cnt     <= '0;
      ks_sync    <= 2'b11;
      stable     <= 1'b1;
      dbc        <= '0;
    end else begin
      retire_q   <= retire;
      halt_q     <= halt;
      we_q       <= writeEn;
      addr_q     <= memAddr;
      data_q     <= writeData;
      retire_cnt <= retire_cnt + CW'(retire_q);
      cycle_cnt  <= halted ? cycle_cnt : cycle_cnt + 1'b1;
      halted     <= halted | halt_q;
      if (we_q) begin
        last_addr <= addr_q;
        last_data <= data_q;
        st_cnt    <= st_cnt + 1'b1;
      end
      ks_sync <= {ks_sync[0], key_n};
      if (ks == stable) dbc <= '0;
      else if (&dbc) begin
        stable <= ks;
        dbc    <= '0;
      end else dbc <= dbc + 1'b1;
    end
  end
  always_ff @(posedge clk) state <= rst ? P0 : state_nx;
  always_comb state_nx = !press ? state : state == P0 ? P1 : state == P1 ? P2 : P0;
  always_comb page = state;
  always_comb begin
    disp = state == P0 ? 24'(retire_cnt) : state == P1 ? 24'(cycle_cnt) :
           {8'(last_addr), st_cnt, 8'(last_data)};
    for (int i = 0; i < 6; i++) seg_nx[i] = seg(disp[4*i +: 4]);
`ifdef RETIRE_MON_BLANK_EN
    begin
      logic lead;
      lead = state != P2;
      for (int i = 5; i > 0; i--) begin
        if (lead && disp[4*i +: 4] == 4'h0) seg_nx[i] = 7'h7F;
        else lead = 1'b0;
      end
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} <= {6{7'h40}};
    else {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} <=
      {seg_nx[5], seg_nx[4], seg_nx[3], seg_nx[2], seg_nx[1], seg_nx[0]};
  end
endmodule

// File: tb/tb_retire_monitor.sv
// tb_retire_monitor: randomized bench against an event-count model of retire_monitor
module tb_retire_monitor;
  localparam int CW = 8, DBW = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic retire = 0, halt = 0, writeEn = 0, key_n = 1;
  logic [5:0] memAddr = 0, writeData = 0;
  logic [1:0] page;
  logic halted;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  int passed = 0, total = 0;
  int n = 0, he = -1, m_ret = 0, m_st = 0, m_page = 0;
  logic [5:0] m_addr = 0, m_data = 0;
  logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  retire_monitor #(.aW(6), .Wwid(6), .CW(CW), .DBW(DBW)) dut (
    .clk(clk), .rst(rst), .retire(retire), .halt(halt), .writeEn(writeEn),
    .memAddr(memAddr), .writeData(writeData), .key_n(key_n), .page(page),
    .halted(halted), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
    .HEX4(HEX4), .HEX5(HEX5));
  always #5 clk = ~clk;
  initial begin
    #5_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  task automatic step(input bit r, input bit h, input bit w, input logic [5:0] a,
                      input logic [5:0] d, input bit k);
    retire = r; halt = h; writeEn = w; memAddr = a; writeData = d; key_n = k;
    @(posedge clk);
    #1;
    if (!rst) begin
      n++;
      m_ret += int'(r);
      if (w) begin
        m_st++;
        m_addr = a;
        m_data = d;
      end
      if (h && he < 0) he = n;
    end
  endtask
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 1);
  endtask
  // a press registers once the key has been seen low for 2**DBW consecutive clocks
  task automatic press(input int len);
    for (int i = 0; i < len; i++) step(0, 0, 0, 0, 0, 0);
    idle(24);
    if (len >= (1 << DBW)) m_page = (m_page + 1) % 3;
  endtask
  // HEX register holds the display computed from state after the previous edge
  function automatic logic [41:0] exp_hex();
    logic [23:0] v;
    logic [41:0] r;
    logic [3:0] nib;
    int cyc;
    cyc = (he >= 0 && n - 1 > he + 1) ? he + 1 : n - 1;
    v = m_page == 0 ? 24'(m_ret % (1 << CW)) : m_page == 1 ? 24'(cyc % (1 << CW)) :
        {2'b00, m_addr, 8'(m_st % 256), 2'b00, m_data};
    r = '0;
    for (int i = 0; i < 6; i++) r[7*i +: 7] = segtab[v[4*i +: 4]];
`ifdef RETIRE_MON_BLANK_EN
    if (m_page != 2)
      for (int i = 5; i > 0; i--) begin
        nib = v[4*i +: 4];
        if (nib != 0) break;
        r[7*i +: 7] = 7'h7F;
      end
`else
    nib = 4'h0;
`endif
    return r;
  endfunction
  task automatic check_all(input string tag);
    chk({tag, "_hex"}, 64'({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}), 64'(exp_hex()));
    chk({tag, "_page"}, 64'(page), 64'(m_page));
    chk({tag, "_halted"}, 64'(halted), 64'(he >= 0 && n >= he + 1));
  endtask
  initial begin
    repeat (3) step(0, 0, 0, 0, 0, 1);
    chk("rst_hex", 64'({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}), 64'({6{7'h40}}));
    chk("rst_page", 64'(page), 64'(0));
    chk("rst_halted", 64'(halted), 64'(0));
    rst = 1'b0;
    repeat (5) step(1, 0, 0, 0, 0, 1);
    idle(3);
    check_all("five");
    press(10);
    check_all("glitch");
    press(20);
    check_all("press1");
    step(0, 0, 1, 6'h2A, 6'h15, 1);
    press(20);
    check_all("store");
    press(20);
    press(20);
    press(20);
    check_all("three");
    press(20);
    check_all("back0");
    for (int i = 0; i < (1 << CW) - 5; i++) step(1, 0, 0, 0, 0, 1);
    idle(3);
    check_all("wrap");
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          int len = $urandom_range(1, 40);
          for (int i = 0; i < len; i++)
            step(1'($urandom), 0, 1'($urandom_range(0, 3) == 0),
                 6'($urandom), 6'($urandom), 1);
        end
        2: press($urandom_range(17, 30));
        default: press($urandom_range(3, 14));
      endcase
      if (it == 8) begin
        idle(10);
        step(0, 1, 0, 0, 0, 1);
        idle(20);
      end
      idle(3);
      check_all($sformatf("rnd%0d", it));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
